// File: rtl/serial_mag_compare_if.sv
// Operand/result bundle between a compare requester and serial_mag_compare.
// The requester drives start/a/b and observes busy/valid/comp_out.
interface serial_mag_compare_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             valid;
  logic [1:0]       comp_out;

  modport master (output start, a, b, input busy, valid, comp_out);
  modport slave  (input start, a, b, output busy, valid, comp_out);
endinterface

// File: rtl/serial_mag_compare.sv
// Bit-serial unsigned magnitude comparator: MSB-first, one bit per clock,
// exits at the first differing bit with a one-cycle valid strobe.
module serial_mag_compare #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  serial_mag_compare_if.slave bus
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] CODE_GT = 2'b10;
  localparam logic [1:0] CODE_LT = 2'b01;
  localparam logic [1:0] CODE_EQ = 2'b00;

  typedef enum logic {
    IDLE = 1'b0,
    CMP  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [1:0]       comp_q, comp_d;

  logic a_bit;
  logic b_bit;

  assign a_bit = a_q[idx_q];
  assign b_bit = b_q[idx_q];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    comp_d  = comp_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          idx_d   = IDX_W'(WIDTH - 1);
          state_d = CMP;
        end
      end
      CMP: begin
        if (a_bit && !b_bit) begin
          comp_d  = CODE_GT;
          valid_d = 1'b1;
          state_d = IDLE;
        end else if (!a_bit && b_bit) begin
          comp_d  = CODE_LT;
          valid_d = 1'b1;
          state_d = IDLE;
        end else if (idx_q == '0) begin
          comp_d  = CODE_EQ;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      comp_q  <= CODE_EQ;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      comp_q  <= comp_d;
    end
  end

  assign bus.busy     = (state_q == CMP);
  assign bus.valid    = valid_q;
  assign bus.comp_out = comp_q;

endmodule

// File: doc/serial_mag_compare.md
# serial_mag_compare

Bit-serial magnitude comparator that sits directly upstream of the comparison-tally logic. It latches two WIDTH-bit operands on a start request and compares them MSB-first, one bit per clock, stopping at the first differing bit. It then emits a 2-bit `comp_out` code with a one-cycle `valid` strobe, which the downstream tally uses to increment its counters.

## Interface
- `WIDTH`, default 4: operand width in bits; legal range is 1 to 16.
- `clk`  in  1  Sole clock; all state changes on the rising edge.
- `reset`  in  1  Synchronous, active-high reset.
- `start`  in  1  Compare request; sampled only while `busy`=0.
- `a`  in  WIDTH  Operand A; sampled on the accepted `start` edge only.
- `b`  in  WIDTH  Operand B; sampled on the accepted `start` edge only.
- `busy`  out  1  High while a comparison is in progress.
- `valid`  out  1  One-cycle strobe: `comp_out` holds a new result.
- `comp_out`  out  2  Result code: 2'b10 means a>b, 2'b01 means a<b, 2'b00 means a==b. 2'b11 is never driven.

## Operation
- Internal registers:
  - `a_reg` and `b_reg`, each WIDTH bits.
  - Bit index `idx`, ceil(log2(WIDTH)) bits, minimum 1 bit.
  - State register with two states: IDLE and CMP.
- IDLE:
  - `busy`=0.
  - On an edge with `start`=1: load `a_reg`←`a`, `b_reg`←`b`, `idx`←WIDTH-1, then go to CMP.
  - On an edge with `start`=0: stay in IDLE.
- CMP, evaluated every edge (`busy`=1):
  - If `a_reg[idx]`=1 and `b_reg[idx]`=0: `comp_out`←2'b10, `valid`←1, go to IDLE.
  - Else if `a_reg[idx]`=0 and `b_reg[idx]`=1: `comp_out`←2'b01, `valid`←1, go to IDLE.
  - Else if `idx`=0: `comp_out`←2'b00, `valid`←1, go to IDLE.
  - Else: `idx`←`idx`-1 and stay in CMP.
- `start` is ignored while in CMP. Requests are not queued.
- Changes on `a`/`b` after the accepted edge have no effect on the comparison in flight.
- `comp_out` holds its last result until the next decision edge overwrites it. It does not change while `busy`=1.
- `valid` is cleared on every edge that is not a decision edge.
- Operands are treated as unsigned.
- `idx` never wraps: the `idx`=0 branch always exits CMP.

## Timing
- Reset (synchronous, edge with `reset`=1, takes priority over all else):
  - State←IDLE, `busy`←0, `valid`←0, `comp_out`←2'b00.
  - `a_reg`←0, `b_reg`←0, `idx`←0.
- Reset asserted mid-comparison aborts it: no `valid` pulse, and `comp_out` returns to 2'b00.
- Let E0 be the edge that accepts `start`, and let k (1..WIDTH) be the 1-based position, counted from the MSB, of the first differing bit (k=WIDTH if the operands are equal).
  - `busy` rises at E0 and falls at E0+k.
  - `valid` is high for exactly one cycle, from edge E0+k to E0+k+1.
  - `comp_out` is updated at edge E0+k.
- Latency is therefore 1 to WIDTH cycles.
- Back-to-back operation: `start` may be asserted in the same cycle that `valid` is high, because `busy`=0 then. It is accepted at E0+k+1, giving zero idle cycles between comparisons.
- WIDTH=1: every comparison has k=1.

## Test plan
1. Reset mid-operation:
   - Stimulus: WIDTH=4, start with a=4'b0001, b=4'b0000; assert `reset` for 1 cycle at E0+2.
   - Required: `busy`=0, `comp_out`=2'b00; `valid` never pulses.
2. MSB decides:
   - Stimulus: a=4'b1010, b=4'b0111.
   - Required: `valid` high only in the cycle after E0+1; `comp_out`=2'b10; `busy` high for 1 cycle.
3. Third bit decides:
   - Stimulus: a=4'b0101, b=4'b0110.
   - Required: `valid` at E0+3; `comp_out`=2'b01; `busy` high for 3 cycles.
4. Equal operands:
   - Stimulus: a=b=4'b1001.
   - Required: `valid` at E0+4; `comp_out`=2'b00.
   - Follow-on: then a=b=4'b0000 → same timing, 2'b00.
5. Busy and back-to-back handling:
   - Stimulus: start with a=4'b0011, b=4'b0010; re-pulse `start` at E0+1 with a=4'b0000, b=4'b1111.
   - Required: the re-pulse is ignored; result is 2'b10 at E0+4.
   - Then: hold `start`=1 with a=4'b1000, b=4'b0000 during that `valid` cycle.
   - Required: accepted at E0+5; 2'b10 result with `valid` at E0+6.
6. Operand isolation:
   - Stimulus: start with a=4'b0100, b=4'b0100; toggle `a` to 4'b1111 every cycle while `busy`=1.
   - Required: `comp_out`=2'b00 at E0+4.
